ser_video_rx: RTL
=================

// Module: ser_video_rx
// PURPOSE
//  Receiving end of the NeoGeo serial video link: deserialises R/G/B pixel words shifted out by the
//  video serialiser (ser_video) and presents them as parallel 7-bit VIDEO_R/G/B with a valid strobe.
//  Sits in the display-side FPGA / test harness and is oversampled by the 24MHz master clock.
//  Also flags framing errors, meaning a wrong bit count between latches.
// PARAMETERS
//  BITS         7   bits per colour channel per pixel, sent MSB first
//  SYNC_STAGES  2   flip-flop stages on every serial input pin (min 2)
// PORTS
//  CLK_24M      in   1     master clock; all logic is on its rising edge
//  nRESET       in   1     asynchronous active-low reset
//  SER_R        in   1     red serial data, changes on falling SER_CLK
//  SER_G        in   1     green serial data
//  SER_B        in   1     blue serial data
//  SER_CLK      in   1     serial bit clock, async to CLK_24M; each phase >= 2 CLK_24M periods
//  SER_LAT      in   1     active-high latch pulse, asserted while SER_CLK low after the last bit
//  ERR_CLR      in   1     synchronous clear of ERR_LEN
//  VIDEO_R      out  BITS  latched red
//  VIDEO_G      out  BITS  latched green
//  VIDEO_B      out  BITS  latched blue
//  PIX_VALID    out  1     one-cycle pulse when VIDEO_* update
//  ERR_LEN      out  1     sticky framing error
//  PIX_CNT      out  16    wrapping count of good pixels
// BEHAVIOUR
//  - Reset (nRESET low, async): all sync flops 0; shift regs 0; bit counter 0;
//    VIDEO_R/G/B = 0; PIX_VALID = 0; ERR_LEN = 0; PIX_CNT = 0.
//  - SER_R/G/B, SER_CLK and SER_LAT each pass through SYNC_STAGES flops. Data and clock have equal
//    delay, so bit alignment is kept.
//  - clk_rise = synced SER_CLK 0->1. lat_rise = synced SER_LAT 0->1.
//  - On clk_rise, each channel does shift <= {shift[BITS-2:0], ser_x}, and bit_cnt increments,
//    saturating at BITS+1.
//  - FSM states: SHIFT, FULL, OVER.
//    - SHIFT: waiting while bit_cnt < BITS. Goes to FULL when bit_cnt reaches BITS.
//    - FULL: exactly BITS bits held. A further clk_rise goes to OVER.
//    - OVER: too many bits. Stays until lat_rise.
//  - lat_rise in FULL:
//    - next cycle: VIDEO_* <= shift regs; PIX_VALID = 1 for one cycle; PIX_CNT += 1 (wraps 0xFFFF->0).
//    - bit_cnt <= 0, FSM -> SHIFT.
//  - lat_rise in SHIFT or OVER: VIDEO_* and PIX_CNT unchanged; ERR_LEN <= 1; bit_cnt <= 0; FSM -> SHIFT.
//  - clk_rise and lat_rise in the same cycle: protocol violation. The latch decision uses the
//    pre-shift state, the shift is discarded, bit_cnt <= 0, and ERR_LEN <= 1.
//  - ERR_CLR clears ERR_LEN. If an error is set in the same cycle, the set wins.
//  - Latency: SER_LAT pin rise -> PIX_VALID is SYNC_STAGES+2 CLK_24M cycles (4 at default).
//  - SER_LAT held high does not re-trigger; only edges count.
//  - Reset mid-word discards the partial word. The first LAT after reset with < BITS bits sets ERR_LEN.
// STRUCTURE
//  - Shared include ser_video_defs.vh holds:
//    - SER_VID_BITS (7), MSB-first ordering, channel order R,G,B;
//    - FSM state encodings (SHIFT=2'd0, FULL=2'd1, OVER=2'd2).
//    The same include is used by ser_video.
//  - Sub-module ser_sync_edge (SYNC_STAGES flops + rising-edge detect), instantiated for SER_CLK
//    and SER_LAT. Data lines use plain sync vectors of the same depth.
// TESTING
//  - Send R=7'h55, G=7'h2A, B=7'h7F (SER_CLK period 8 cycles), then LAT:
//    PIX_VALID once 4 cycles after LAT pin rise; VIDEO=55/2A/7F; PIX_CNT=1; ERR_LEN=0.
//  - 6 clocks then LAT: ERR_LEN=1, VIDEO unchanged, no PIX_VALID. Then a good word 7'h01 on all
//    channels gives PIX_VALID and VIDEO=01, and ERR_LEN stays 1 until an ERR_CLR pulse clears it.
//  - 8 clocks then LAT: ERR_LEN=1, no PIX_VALID, PIX_CNT unchanged.
//  - Preload PIX_CNT to 16'hFFFF via 65535 good pixels (or force), send one more good pixel:
//    PIX_CNT=0, PIX_VALID=1.
//  - nRESET low after 4 of 7 bits, release, send 3 bits + LAT: ERR_LEN=1. A following full word
//    latches correctly.
//  - SER_CLK at minimum 2+2 cycle phases, 100 random pixels: every VIDEO triple matches the
//    scoreboard, ERR_LEN=0.

Source files
------------

// File: rtl/ser_video_rx_pkg.sv
// Shared types and constants for the NeoGeo serial video receiver.
// Word width, channel ordering and receive FSM state encodings.
package ser_video_rx_pkg;

    localparam int SER_VID_BITS = 7;
    localparam int SER_VID_SYNC = 2;
    localparam int PIX_CNT_W    = 16;

    typedef enum logic [1:0] {
        ST_SHIFT = 2'd0,
        ST_FULL  = 2'd1,
        ST_OVER  = 2'd2
    } rx_state_e;

    // Channel order R,G,B: r lands in the MSB of the packed vector
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_bit_t;

endpackage

// File: rtl/ser_sync_edge.sv
// Multi-stage synchroniser with a registered rising-edge pulse.
// The pulse lags the synchronised level by one cycle.
module ser_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/ser_video_rx.sv
// NeoGeo serial video receiver: oversamples SER_CLK/SER_LAT at 24MHz,
// deserialises R/G/B words and flags wrong bit counts between latches.
module ser_video_rx
    import ser_video_rx_pkg::*;
#(
    parameter int BITS        = SER_VID_BITS,
    parameter int SYNC_STAGES = SER_VID_SYNC
) (
    input  logic                 CLK_24M,
    input  logic                 nRESET,
    input  logic                 SER_R,
    input  logic                 SER_G,
    input  logic                 SER_B,
    input  logic                 SER_CLK,
    input  logic                 SER_LAT,
    input  logic                 ERR_CLR,
    output logic [BITS-1:0]      VIDEO_R,
    output logic [BITS-1:0]      VIDEO_G,
    output logic [BITS-1:0]      VIDEO_B,
    output logic                 PIX_VALID,
    output logic                 ERR_LEN,
    output logic [PIX_CNT_W-1:0] PIX_CNT
);

    localparam int            CW       = $clog2(BITS + 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);

    logic clk_rise;
    logic lat_rise;

    ser_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk   (CLK_24M),
        .rst_n (nRESET),
        .din   (SER_CLK),
        .rise  (clk_rise)
    );

    ser_sync_edge #(.STAGES(SYNC_STAGES)) u_lat_sync (
        .clk   (CLK_24M),
        .rst_n (nRESET),
        .din   (SER_LAT),
        .rise  (lat_rise)
    );

    // One extra stage keeps data aligned with the registered edge pulse
    rgb_bit_t [SYNC_STAGES:0] dsync_q, dsync_d;
    logic [2:0]               dbit;

    logic [2:0][BITS-1:0]     sh_q, sh_d;
    logic [2:0][BITS-1:0]     video_q, video_d;
    logic [CW-1:0]            bit_cnt_q, bit_cnt_d;
    rx_state_e                state_q, state_d;
    logic                     pix_valid_q, pix_valid_d;
    logic                     err_q, err_d;
    logic [PIX_CNT_W-1:0]     pix_cnt_q, pix_cnt_d;

    assign dbit = dsync_q[SYNC_STAGES];

    always_comb begin
        dsync_d     = {dsync_q[SYNC_STAGES-1:0], {SER_R, SER_G, SER_B}};
        sh_d        = sh_q;
        video_d     = video_q;
        bit_cnt_d   = bit_cnt_q;
        state_d     = state_q;
        pix_valid_d = 1'b0;
        err_d       = err_q & ~ERR_CLR;
        pix_cnt_d   = pix_cnt_q;

        if (lat_rise) begin
            // A coincident clk_rise is dropped; decision uses pre-shift state
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
            if (state_q == ST_FULL) begin
                video_d     = sh_q;
                pix_valid_d = 1'b1;
                pix_cnt_d   = pix_cnt_q + PIX_CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end
            if (clk_rise) begin
                err_d = 1'b1;
            end
        end else if (clk_rise) begin
            for (int c = 0; c < 3; c++) begin
                sh_d[c] = {sh_q[c][BITS-2:0], dbit[c]};
            end
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
            unique case (state_q)
                ST_SHIFT: begin
                    if (bit_cnt_q == CNT_LAST) begin
                        state_d = ST_FULL;
                    end
                end
                ST_FULL:  state_d = ST_OVER;
                default:  state_d = ST_OVER;
            endcase
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            dsync_q     <= '0;
            sh_q        <= '0;
            video_q     <= '0;
            bit_cnt_q   <= '0;
            state_q     <= ST_SHIFT;
            pix_valid_q <= 1'b0;
            err_q       <= 1'b0;
            pix_cnt_q   <= '0;
        end else begin
            dsync_q     <= dsync_d;
            sh_q        <= sh_d;
            video_q     <= video_d;
            bit_cnt_q   <= bit_cnt_d;
            state_q     <= state_d;
            pix_valid_q <= pix_valid_d;
            err_q       <= err_d;
            pix_cnt_q   <= pix_cnt_d;
        end
    end

    assign VIDEO_R   = video_q[2];
    assign VIDEO_G   = video_q[1];
    assign VIDEO_B   = video_q[0];
    assign PIX_VALID = pix_valid_q;
    assign ERR_LEN   = err_q;
    assign PIX_CNT   = pix_cnt_q;

endmodule
